// File: rtl/latency_ram.sv
// Behavioural main memory with programmable BUSY latency behind a single request bus.
// Optional macro RAM_STATS_EN adds completed-read/write counters (rdcount, wrcount).
module latency_ram #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 16384
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
`ifdef RAM_STATS_EN
    ,
    output logic [31:0] rdcount,
    output logic [31:0] wrcount
`endif
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // A held request is BUSY for LAT+1 cycles, so the counter saturates one past LAT.
    localparam logic [4:0]  CNT_MAX = 5'(LAT + 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    logic [29:0]   r_req_addr;
    op_t           r_req_op;
    logic [4:0]    r_cnt;
    logic [31:0]   r_mem [DEPTH];

    ramstate_t     w_state;
    op_t           w_op;
    logic          w_valid;
    logic          w_match;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_unused = ^ramaddr[1:0];

    always_comb begin
        w_op    = ramWEN ? OP_WRITE : OP_READ;
        w_idx   = ramaddr[2 +: AW];
        w_match = (ramaddr[31:2] == r_req_addr) && (w_op == r_req_op);
        w_valid = 1'b0;
        w_state = FREE;
        ramload = '0;
        if (!nRST) begin
            w_state = FREE;
        end else if (!ramREN && !ramWEN) begin
            w_state = FREE;
        end else if (ramREN && ramWEN) begin
            w_state = ERROR;
        end else if ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)) begin
            w_state = ERROR;
        end else begin
            w_valid = 1'b1;
            w_state = (w_match && (r_cnt == CNT_MAX)) ? ACCESS : BUSY;
        end
        if (w_state == ACCESS) begin
            ramload = r_mem[w_idx];
        end
        ramstate = w_state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_req_addr <= '0;
            r_req_op   <= OP_READ;
            r_cnt      <= '0;
        end else if (w_valid) begin
            if (!w_match) begin
                r_req_addr <= ramaddr[31:2];
                r_req_op   <= w_op;
                r_cnt      <= 5'd1;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if ((w_state == ACCESS) && (r_req_op == OP_WRITE)) begin
            r_mem[w_idx] <= ramstore;
        end
    end

`ifdef RAM_STATS_EN
    logic        r_acc_seen;
    logic [31:0] r_rdcount;
    logic [31:0] r_wrcount;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_acc_seen <= 1'b0;
            r_rdcount  <= '0;
            r_wrcount  <= '0;
        end else begin
            r_acc_seen <= (w_state == ACCESS);
            if ((w_state == ACCESS) && !r_acc_seen) begin
                if (r_req_op == OP_WRITE) begin
                    r_wrcount <= r_wrcount + 32'd1;
                end else begin
                    r_rdcount <= r_rdcount + 32'd1;
                end
            end
        end
    end

    assign rdcount = r_rdcount;
    assign wrcount = r_wrcount;
`endif

endmodule

// File: tb/tb_latency_ram.sv
// Self-checking bench for latency_ram: directed vector table, reset/stat sequences,
// and randomized traffic checked against a request-history reference model.
module tb_latency_ram;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 16384;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef RAM_STATS_EN
    logic [31:0] rdcount;
    logic [31:0] wrcount;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    latency_ram #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef RAM_STATS_EN
        ,
        .rdcount  (rdcount),
        .wrcount  (wrcount)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: identity and age of the request held in consecutive cycles.
    bit          m_have;
    logic [29:0] m_word;
    bit          m_wr;
    int unsigned m_k;
    int unsigned m_rd_cnt;
    int unsigned m_wr_cnt;
    logic [31:0] mdl_mem [int unsigned];

    typedef struct {
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] ld;
        bit          cl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample at negedge, update model after posedge.
    task automatic cyc(input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] data, input bit use_exp, input logic [1:0] es,
                       input logic [31:0] el, input bit ecl, input string nm);
        logic [29:0] w;
        logic [1:0]  ps;
        logic [31:0] pl;
        bit          pcl;
        int unsigned k;
        bit          rst_now;
        w   = addr[31:2];
        k   = 0;
        pl  = '0;
        pcl = 1'b1;
        if (!nRST || (!ren && !wen)) begin
            ps = S_FREE;
        end else if ((ren && wen) || (int'(w) >= int'(DEPTH))) begin
            ps = S_ERROR;
        end else begin
            k  = (m_have && (m_word == w) && (m_wr == wen)) ? m_k + 1 : 0;
            ps = (k > LAT) ? S_ACCESS : S_BUSY;
        end
        if (ps == S_ACCESS) begin
            pcl = 1'b0;
            if (!wen && mdl_mem.exists(int'(w))) begin
                pl  = mdl_mem[int'(w)];
                pcl = 1'b1;
            end
        end
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = addr;
        ramstore = data;
        #4;
        rst_now = !nRST;
        if (use_exp) begin
            chk({nm, ".state"}, {30'd0, ramstate}, {30'd0, es});
            if (ecl) chk({nm, ".load"}, ramload, el);
        end else begin
            chk({nm, ".state"}, {30'd0, ramstate}, {30'd0, ps});
            if (pcl) chk({nm, ".load"}, ramload, pl);
        end
        @(posedge CLK);
        if (rst_now || !nRST) begin
            m_have   = 1'b0;
            m_rd_cnt = 0;
            m_wr_cnt = 0;
        end else if (ps == S_BUSY || ps == S_ACCESS) begin
            m_have = 1'b1;
            m_word = w;
            m_wr   = wen;
            m_k    = (k > LAT + 1) ? LAT + 1 : k;
            if (k == LAT + 1) begin
                if (wen) m_wr_cnt++;
                else     m_rd_cnt++;
            end
            if (ps == S_ACCESS && wen) mdl_mem[int'(w)] = data;
        end else begin
            m_have = 1'b0;
        end
        #1;
    endtask

    function automatic void add(input bit ren, input bit wen, input logic [31:0] addr,
                                input logic [31:0] data, input logic [1:0] st,
                                input logic [31:0] ld, input bit cl);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = addr; v.data = data;
        v.st = st; v.ld = ld; v.cl = cl;
        vecs.push_back(v);
    endfunction

    // Held request with LAT=2: three BUSY cycles then the first ACCESS cycle.
    function automatic void add_held(input bit wen, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [31:0] ld,
                                     input bit cl);
        for (int i = 0; i < 3; i++) add(!wen, wen, addr, data, S_BUSY, '0, 1'b1);
        add(!wen, wen, addr, data, S_ACCESS, ld, cl);
    endfunction

    task automatic do_reset();
        nRST = 1'b0;
        cyc(1'b0, 1'b0, '0, '0, 1'b1, S_FREE, '0, 1'b1, "rst_idle");
        nRST = 1'b1;
    endtask

    initial begin
        logic        h_ren, h_wen;
        logic [31:0] h_addr, h_data;
        logic [31:0] pool [6];
        int unsigned r;

        nRST = 1'b0; ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h40; ramstore = '0;
        m_have = 1'b0; m_k = 0; m_word = '0; m_wr = 1'b0; m_rd_cnt = 0; m_wr_cnt = 0;
        #2;
        chk("reset.state", {30'd0, ramstate}, {30'd0, S_FREE});
        chk("reset.load", ramload, '0);
`ifdef RAM_STATS_EN
        chk("reset.rdcount", rdcount, '0);
        chk("reset.wrcount", wrcount, '0);
`endif
        ramREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;

        add(1'b0, 1'b0, 32'h0, 32'h0, S_FREE, '0, 1'b1);
        add_held(1'b1, 32'h10,   32'hA5A5_0010, '0, 1'b0);
        add_held(1'b1, 32'h104,  32'h1040_1040, '0, 1'b0);
        add_held(1'b1, 32'hFFFC, 32'h0BAD_F00D, '0, 1'b0);
        add_held(1'b1, 32'h40,   32'hDEAD_BEEF, '0, 1'b0);
        add_held(1'b0, 32'h40,   32'h0, 32'hDEAD_BEEF, 1'b1);
        add(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, S_ERROR, '0, 1'b1);
        add_held(1'b0, 32'h10,   32'h0, 32'hA5A5_0010, 1'b1);
        add(1'b1, 1'b0, 32'h10000, 32'h0, S_ERROR, '0, 1'b1);
        add_held(1'b0, 32'hFFFC, 32'h0, 32'h0BAD_F00D, 1'b1);
        add(1'b1, 1'b0, 32'h100, 32'h0, S_BUSY, '0, 1'b1);
        add(1'b1, 1'b0, 32'h100, 32'h0, S_BUSY, '0, 1'b1);
        add_held(1'b0, 32'h104,  32'h0, 32'h1040_1040, 1'b1);
        add(1'b1, 1'b0, 32'h107, 32'h0, S_ACCESS, 32'h1040_1040, 1'b1);
        add(1'b1, 1'b0, 32'h107, 32'h0, S_ACCESS, 32'h1040_1040, 1'b1);
        add_held(1'b0, 32'h40,   32'h0, 32'hDEAD_BEEF, 1'b1);
        add(1'b0, 1'b0, 32'h40, 32'h0, S_FREE, '0, 1'b1);
        add_held(1'b0, 32'h40,   32'h0, 32'hDEAD_BEEF, 1'b1);
        add(1'b0, 1'b0, 32'h0, 32'h0, S_FREE, '0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data, 1'b1,
                vecs[i].st, vecs[i].ld, vecs[i].cl, $sformatf("vec%0d", i));
        end

        // Reset during a write's BUSY phase must abandon the write.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h200, 32'h1111_2222, 1'b0, '0, '0, 1'b0, "wr200_old");
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, "idle");
        cyc(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1'b1, S_BUSY, '0, 1'b1, "wr200_new0");
        cyc(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1'b1, S_BUSY, '0, 1'b1, "wr200_new1");
        nRST = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h200, 32'h1234_5678, 1'b1, S_FREE, '0, 1'b1, "in_reset");
        nRST = 1'b1;
        cyc(1'b0, 1'b0, '0, '0, 1'b1, S_FREE, '0, 1'b1, "post_rst_idle");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h200, '0, 1'b1, S_BUSY, '0, 1'b1, "rd200_busy");
        cyc(1'b1, 1'b0, 32'h200, '0, 1'b1, S_ACCESS, 32'h1111_2222, 1'b1, "rd200_access");
        cyc(1'b0, 1'b0, '0, '0, 1'b1, S_FREE, '0, 1'b1, "idle2");

`ifdef RAM_STATS_EN
        do_reset();
        chk("stats.rst_rd", rdcount, '0);
        chk("stats.rst_wr", wrcount, '0);
        for (int t = 0; t < 5; t++) begin
            h_wen  = (t >= 3);
            h_addr = (t == 0) ? 32'h40 : (t == 1) ? 32'h10 : (t == 2) ? 32'hFFFC :
                     (t == 3) ? 32'h300 : 32'h304;
            for (int c = 0; c < 7; c++) cyc(!h_wen, h_wen, h_addr, 32'hC0DE_0000 + t, 1'b0, '0, '0, 1'b0, "stats_txn");
            cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, "stats_idle");
        end
        chk("stats.rdcount", rdcount, 32'd3);
        chk("stats.wrcount", wrcount, 32'd2);
        do_reset();
        chk("stats.clr_rd", rdcount, '0);
        chk("stats.clr_wr", wrcount, '0);
`endif

        pool[0] = 32'h40;  pool[1] = 32'h44;    pool[2] = 32'h10;
        pool[3] = 32'hFFFC; pool[4] = 32'h10000; pool[5] = 32'hFFFF_FFF0;
        h_ren = 1'b0; h_wen = 1'b0; h_addr = '0; h_data = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r      = $urandom_range(0, 9);
                h_ren  = (r != 0) && ((r == 1) || (r >= 6));
                h_wen  = (r != 0) && (r <= 5);
                h_addr = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
                h_data = $urandom;
            end
            cyc(h_ren, h_wen, h_addr, h_data, 1'b0, '0, '0, 1'b0, $sformatf("rand%0d", n));
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, "rand_end");
`ifdef RAM_STATS_EN
        chk("rand.rdcount", rdcount, m_rd_cnt);
        chk("rand.wrcount", wrcount, m_wr_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
